// File: rtl/div_pkg.sv
// =====================================================================
// Module      : div_pkg
// Description : Shared types and constants for the divider controller.
//               Controller state encoding and the divide-by-zero
//               quotient pattern (all ones at any operand width).
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

    localparam int c_MAX_W = 64;

    // All-ones pattern of the requested width, right-aligned in c_MAX_W bits.
    function automatic logic [c_MAX_W-1:0] dbz_q(input int width);
        return {c_MAX_W{1'b1}} >> (c_MAX_W - width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_req_fifo.sv
// =====================================================================
// Module      : div_req_fifo
// Description : Small request FIFO holding {tag, y, x} records for the
//               divider controller. Head is presented combinationally.
//               DEPTH must be a power of two, >= 2.
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

module div_req_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == (c_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// =====================================================================
// Module      : div_ctrl
// Description : Request front-end and result collector around an
//               iterative divider. Buffers tagged requests, launches one
//               division at a time and returns q/r/dbz/tag in order.
//               Optional macro DIV_CTRL_DBZ_BYPASS_EN: y==0 requests are
//               answered directly without using the divider.
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none

module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    input  logic             div_busy,
    input  logic             div_valid,
    input  logic             div_dbz,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_dbz,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int                   c_DW       = 2*WIDTH + TAG_W;
    localparam logic [c_MAX_W-1:0]   c_DBZ_FULL = dbz_q(WIDTH);
    localparam logic [WIDTH-1:0]     c_DBZ_Q    = c_DBZ_FULL[WIDTH-1:0];

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_start;
    logic             w_capture;
    logic [c_DW-1:0]  w_head;
    logic [WIDTH-1:0] w_head_x;
    logic [WIDTH-1:0] w_head_y;
    logic [TAG_W-1:0] w_head_tag;
    logic [WIDTH-1:0] w_cap_q;
    logic [WIDTH-1:0] w_cap_r;
    logic             w_cap_dbz;
    logic             w_unused_div_valid;

    // Completion is judged from div_busy alone; div_valid is not needed.
    assign w_unused_div_valid = div_valid;

    assign {w_head_tag, w_head_y, w_head_x} = w_head;
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign div_x     = w_head_x;
    assign div_y     = w_head_y;
    assign div_start = w_start;
    assign rsp_valid = (r_state == RESP);

    div_req_fifo #(
        .DW    (c_DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({req_tag, req_y, req_x}),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, launch pulse, FIFO pop and the value to capture.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_cap_q     = div_q;
        w_cap_r     = div_r;
        w_cap_dbz   = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef DIV_CTRL_DBZ_BYPASS_EN
                if (!w_empty && (w_head_y == '0)) begin
                    w_capture   = 1'b1;
                    w_pop       = 1'b1;
                    w_cap_q     = c_DBZ_Q;
                    w_cap_r     = w_head_x;
                    w_cap_dbz   = 1'b1;
                    w_state_nxt = RESP;
                end else if (!w_empty && !div_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = WAIT;
                end
`else
                // div_busy gate also covers a divider still running from before reset.
                if (!w_empty && !div_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = WAIT;
                end
`endif
            end
            WAIT: begin
                if (!div_busy) begin
                    w_capture   = 1'b1;
                    w_pop       = 1'b1;
                    w_state_nxt = RESP;
                    if (div_dbz) begin
                        w_cap_q   = c_DBZ_Q;
                        w_cap_r   = w_head_x;
                        w_cap_dbz = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response holding registers; stable for the whole RESP state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_dbz <= 1'b0;
            rsp_tag <= '0;
        end else if (w_capture) begin
            rsp_q   <= w_cap_q;
            rsp_r   <= w_cap_r;
            rsp_dbz <= w_cap_dbz;
            rsp_tag <= w_head_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// =====================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl with a behavioural
//               iterative divider (WIDTH busy cycles, immediate dbz).
// Revision    : 1.0 - initial release
// =====================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int TAG_W = 2;
`ifdef DIV_CTRL_DBZ_BYPASS_EN
    localparam int  DBZ_LAT  = 2;
    localparam bit  BYPASS   = 1'b1;
`else
    localparam int  DBZ_LAT  = 3;
    localparam bit  BYPASS   = 1'b0;
`endif
    localparam int  DIV_LAT  = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic [TAG_W-1:0] req_tag;
    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_dbz;
    logic [TAG_W-1:0] rsp_tag;

    // Behavioural divider (no reset, like the real one).
    logic             m_busy  = 1'b0;
    logic             m_valid = 1'b0;
    logic             m_dbz   = 1'b0;
    logic [WIDTH-1:0] m_q     = '0;
    logic [WIDTH-1:0] m_r     = '0;
    logic [WIDTH-1:0] m_x     = '0;
    logic [WIDTH-1:0] m_y     = '0;
    int               m_cnt   = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_tag   (req_tag),
        .div_start (div_start),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_busy  (m_busy),
        .div_valid (m_valid),
        .div_dbz   (m_dbz),
        .div_q     (m_q),
        .div_r     (m_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .rsp_tag   (rsp_tag)
    );

    always @(posedge clk) begin
        if (div_start) begin
            m_valid <= 1'b0;
            if (div_y == '0) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_dbz   <= 1'b1;
                m_q     <= '1;
                m_r     <= div_x;
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= WIDTH;
                m_dbz  <= 1'b0;
                m_x    <= div_x;
                m_y    <= div_y;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_q     <= m_x / m_y;
                m_r     <= m_x % m_y;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one request and hold it until accepted; returns one cycle after the push edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        req_x = x; req_y = y; req_tag = tag; req_valid = 1'b1;
        while (!req_ready && n < 100) begin
            tick;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 expected 1");
        end
        tick;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, compare it, then complete the handshake.
    task automatic expect_rsp(input string name, input logic [WIDTH-1:0] q,
                              input logic [WIDTH-1:0] r, input logic dbz,
                              input logic [TAG_W-1:0] tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick;
            n++;
        end
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_qrdt"}, {rsp_q, rsp_r, rsp_dbz, rsp_tag}, {q, r, dbz, tag});
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    logic [2*WIDTH+1+TAG_W-1:0] expq [$];
    logic [WIDTH-1:0]           sx, sy;
    logic                       stable, ok;
    int                         lat, got, cyc, n;
    logic                       saw_start;

    initial begin
        vecs[0] = '{4'd13, 4'd4,  2'd1, 4'd3,  4'd1, 1'b0, DIV_LAT};
        vecs[1] = '{4'd9,  4'd0,  2'd2, 4'd15, 4'd9, 1'b1, DBZ_LAT};
        vecs[2] = '{4'd7,  4'd2,  2'd3, 4'd3,  4'd1, 1'b0, DIV_LAT};
        vecs[3] = '{4'd15, 4'd15, 2'd0, 4'd1,  4'd0, 1'b0, DIV_LAT};
        vecs[4] = '{4'd0,  4'd3,  2'd1, 4'd0,  4'd0, 1'b0, DIV_LAT};
        vecs[5] = '{4'd5,  4'd7,  2'd2, 4'd0,  4'd5, 1'b0, DIV_LAT};
        vecs[6] = '{4'd15, 4'd1,  2'd3, 4'd15, 4'd0, 1'b0, DIV_LAT};
        vecs[7] = '{4'd0,  4'd0,  2'd0, 4'd15, 4'd0, 1'b1, DBZ_LAT};
        vecs[8] = '{4'd14, 4'd5,  2'd1, 4'd2,  4'd4, 1'b0, DIV_LAT};

        rst_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_tag = '0;
        rsp_ready = 1'b0;
        tick; tick;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fields", {rsp_q, rsp_r, rsp_dbz, rsp_tag}, 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        tick;

        // Table-driven single operations with latency from the accept cycle.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].tag);
            lat = 1;
            saw_start = div_start;
            while (!rsp_valid && lat < 60) begin
                tick;
                lat++;
                saw_start = saw_start | div_start;
            end
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_start", i), 32'(saw_start),
                  32'(!(BYPASS && vecs[i].y == '0)));
            check($sformatf("vec%0d_q", i), 32'(rsp_q), 32'(vecs[i].q));
            check($sformatf("vec%0d_r", i), 32'(rsp_r), 32'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), 32'(rsp_dbz), 32'(vecs[i].dbz));
            check($sformatf("vec%0d_tag", i), 32'(rsp_tag), 32'(vecs[i].tag));
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
            check($sformatf("vec%0d_valid_drop", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure: full FIFO deasserts ready, response holds steady.
        send(4'd7, 4'd2, 2'd0);
        send(4'd15, 4'd15, 2'd1);
        req_x = 4'd0; req_y = 4'd3; req_tag = 2'd2; req_valid = 1'b1;
        check("bp_full_ready", 32'(req_ready), 32'd0);
        send(4'd0, 4'd3, 2'd2);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(rsp_valid && rsp_q == 4'd3 && rsp_r == 4'd1 && rsp_tag == 2'd0))
                stable = 1'b0;
            tick;
        end
        check("bp_hold_stable", 32'(stable), 32'd1);
        expect_rsp("bp_rsp0", 4'd3, 4'd1, 1'b0, 2'd0);
        expect_rsp("bp_rsp1", 4'd1, 4'd0, 1'b0, 2'd1);
        expect_rsp("bp_rsp2", 4'd0, 4'd0, 1'b0, 2'd2);

        // Push in the capture cycle: count must stay at one, then fill.
        repeat (8) tick;
        send(4'd11, 4'd3, 2'd1);
        repeat (5) tick;
        check("pp_ready_capture", 32'(req_ready), 32'd1);
        send(4'd6, 4'd4, 2'd2);
        send(4'd9, 4'd2, 2'd3);
        check("pp_full_after", 32'(req_ready), 32'd0);
        check("pp_rsp_valid", 32'(rsp_valid), 32'd1);
        expect_rsp("pp_rsp0", 4'd3, 4'd2, 1'b0, 2'd1);
        expect_rsp("pp_rsp1", 4'd1, 4'd2, 1'b0, 2'd2);
        expect_rsp("pp_rsp2", 4'd4, 4'd1, 1'b0, 2'd3);

        // Reset two cycles after a launch while the divider is busy.
        repeat (8) tick;
        send(4'd15, 4'd2, 2'd0);
        tick; tick;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        tick;
        rst_n = 1'b1;
        check("mid_rst_fields", {rsp_q, rsp_r, rsp_dbz, rsp_tag}, 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        send(4'd8, 4'd3, 2'd1);
        ok = 1'b1;
        n = 0;
        while (m_busy && n < 20) begin
            if (div_start || rsp_valid) ok = 1'b0;
            tick;
            n++;
        end
        check("mid_rst_no_start", 32'(ok), 32'd1);
        expect_rsp("mid_rst_rsp", 4'd2, 4'd2, 1'b0, 2'd1);

        // Full sweep with random response backpressure.
        repeat (8) tick;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    sx = 4'(i >> 4);
                    sy = 4'(i);
                    if (sy == '0)
                        expq.push_back({4'hF, sx, 1'b1, 2'(i)});
                    else
                        expq.push_back({4'(sx / sy), 4'(sx % sy), 1'b0, 2'(i)});
                    send(sx, sy, 2'(i));
                end
            end
            begin
                got = 0;
                cyc = 0;
                while (got < 256 && cyc < 20000) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (rsp_valid && rsp_ready) begin
                        if (expq.size() == 0) begin
                            check("sweep_unexpected", 32'd1, 32'd0);
                        end else begin
                            check($sformatf("sweep_rsp%0d", got),
                                  {rsp_q, rsp_r, rsp_dbz, rsp_tag}, 32'(expq.pop_front()));
                        end
                        got++;
                    end
                    tick;
                    cyc++;
                end
                rsp_ready = 1'b0;
                check("sweep_count", got, 256);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
